// File: rtl/btb_file_pkg.sv
// Shared constants, field offsets and types for the 2-way, 8-set branch target buffer.
// Set layout: way1 = [127:64], way2 = [63:0]; each way is {valid, tag, target, state, 2'b00}.
package btb_file_pkg;

   localparam int unsigned SETS     = 8;
   localparam int unsigned BTB_SETS = SETS;
   localparam int unsigned IDX_W    = $clog2(SETS);
   localparam int unsigned TAG_W    = 27;

   localparam int unsigned VALID_BIT = 63;
   localparam int unsigned TAG_MSB   = 62;
   localparam int unsigned TAG_LSB   = 36;
   localparam int unsigned TGT_MSB   = 35;
   localparam int unsigned TGT_LSB   = 4;
   localparam int unsigned ST_MSB    = 3;
   localparam int unsigned ST_LSB    = 2;

   typedef enum logic [1:0] {
      STRONG_NOT_TAKEN = 2'b00,
      WEAK_NOT_TAKEN   = 2'b01,
      WEAK_TAKEN       = 2'b10,
      STRONG_TAKEN     = 2'b11
   } bp_state_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } flush_state_t;

   typedef logic [IDX_W-1:0] btb_index_t;
   typedef logic [TAG_W-1:0] btb_tag_t;
   typedef logic [63:0]      btb_way_t;
   typedef logic [127:0]     btb_set_t;

endpackage

// File: rtl/btb_file_if.sv
// IF-lookup, EX-update and flush signals of the BTB storage stage.
// master = the fetch/update logic driving requests; slave = btb_file.
interface btb_file_if;

   logic         read_en;
   logic [31:0]  read_pc;
   logic         predict_valid;
   logic         predict_taken;
   logic [31:0]  predict_target;

   logic         update_en;
   logic [31:0]  update_pc;
   logic [127:0] update_set;
   logic [7:0]   lru_out;
   logic [26:0]  update_tag;
   logic [2:0]   update_index;
   logic [127:0] write_set;
   logic         next_lru_write;

   logic         flush;
   logic         flush_busy;

   modport master (
      output read_en, read_pc, update_en, update_pc, write_set, next_lru_write, flush,
      input  predict_valid, predict_taken, predict_target, update_set, lru_out,
             update_tag, update_index, flush_busy
   );

   modport slave (
      input  read_en, read_pc, update_en, update_pc, write_set, next_lru_write, flush,
      output predict_valid, predict_taken, predict_target, update_set, lru_out,
             update_tag, update_index, flush_busy
   );

endinterface

// File: rtl/btb_file_lookup.sv
// Combinational tag match over one 2-way set; way1 takes priority if both ways hit.
// hit_way: 0 = way1, 1 = way2.
module btb_lookup
   import btb_file_pkg::*;
(
   input  btb_set_t    set,
   input  btb_tag_t    tag,
   output logic        hit,
   output logic        hit_way,
   output logic [31:0] target,
   output bp_state_t   state
);

   btb_way_t way1;
   btb_way_t way2;
   logic     hit1;
   logic     hit2;
   logic     unused_low;

   assign way1       = set[127:64];
   assign way2       = set[63:0];
   assign hit1       = way1[VALID_BIT] && (way1[TAG_MSB:TAG_LSB] == tag);
   assign hit2       = way2[VALID_BIT] && (way2[TAG_MSB:TAG_LSB] == tag);
   assign unused_low = ^{way1[1:0], way2[1:0]};

   always_comb begin
      hit     = hit1 || hit2;
      hit_way = 1'b0;
      target  = '0;
      state   = STRONG_NOT_TAKEN;
      if (hit1) begin
         target = way1[TGT_MSB:TGT_LSB];
         state  = bp_state_t'(way1[ST_MSB:ST_LSB]);
      end else if (hit2) begin
         hit_way = 1'b1;
         target  = way2[TGT_MSB:TGT_LSB];
         state   = bp_state_t'(way2[ST_MSB:ST_LSB]);
      end
   end

endmodule

// File: rtl/btb_file.sv
// BTB set array + LRU vector: combinational IF prediction, EX commit at the edge,
// and an 8-cycle invalidate sweep that blocks commits and predictions while running.
module btb_file
   import btb_file_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   btb_file_if.slave  bus
);

   btb_set_t     sets [SETS];
   logic [SETS-1:0] lru;

   flush_state_t state;
   flush_state_t state_next;
   btb_index_t   cnt;
   btb_index_t   cnt_next;
   logic         busy;

   btb_index_t   read_index;
   btb_tag_t     read_tag;
   btb_index_t   update_index;
   logic         hit;
   logic         hit_way;
   logic [31:0]  hit_target;
   bp_state_t    hit_state;
   logic         predict_valid;
   logic         commit;
   logic         touch;
   logic         unused_bits;

   assign read_index   = bus.read_pc[4:2];
   assign read_tag     = bus.read_pc[31:5];
   assign update_index = bus.update_pc[4:2];
   assign unused_bits  = ^{bus.read_pc[1:0], bus.update_pc[1:0], hit_state[0]};

   btb_lookup u_lookup (
      .set     (sets[read_index]),
      .tag     (read_tag),
      .hit     (hit),
      .hit_way (hit_way),
      .target  (hit_target),
      .state   (hit_state)
   );

   assign predict_valid = bus.read_en && !busy && hit;
   assign commit        = bus.update_en && !busy;
   // An EX commit to the same index owns the LRU bit this cycle.
   assign touch         = predict_valid && !(commit && (update_index == read_index));

   assign bus.predict_valid  = predict_valid;
   assign bus.predict_taken  = predict_valid && hit_state[1];
   assign bus.predict_target = predict_valid ? hit_target : '0;
   assign bus.update_set     = sets[update_index];
   assign bus.lru_out        = lru;
   assign bus.update_tag     = bus.update_pc[31:5];
   assign bus.update_index   = update_index;
   assign bus.flush_busy     = busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         IDLE: begin
            if (bus.flush) begin
               state_next = SWEEP;
               cnt_next   = '0;
            end
         end
         SWEEP: begin
            if (bus.flush) begin
               cnt_next = '0;
            end else if (cnt == btb_index_t'(SETS - 1)) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + btb_index_t'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_comb begin
      busy = (state == SWEEP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SETS; i++) begin
            sets[i] <= '0;
         end
         lru <= '0;
      end else if (busy) begin
         sets[cnt][127]      <= 1'b0;
         sets[cnt][VALID_BIT] <= 1'b0;
         lru[cnt]            <= 1'b0;
      end else begin
         if (commit) begin
            sets[update_index] <= bus.write_set;
            lru[update_index]  <= bus.next_lru_write;
         end
         // Hit on way1 makes way2 the victim and vice versa.
         if (touch) begin
            lru[read_index] <= hit_way;
         end
      end
   end

endmodule

// File: tb/tb_btb_file.sv
// Randomised and directed checks of btb_file against an array-level reference model
// of the BTB (sets, LRU vector, sweep position).
module tb_btb_file;
   import btb_file_pkg::*;

   logic clk;
   logic rst_n;

   btb_file_if bus ();

   btb_file dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec;
   int unsigned n_bad;

   logic [127:0] m_set [8];
   logic [7:0]   m_lru;
   bit           m_busy;
   int           m_pos;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 8; i++) m_set[i] = '0;
      m_lru  = '0;
      m_busy = 0;
      m_pos  = 0;
   endtask

   // Scan ways in priority order; first valid way whose tag matches wins.
   function automatic void m_predict(input logic [31:0] pc, output bit hit, output bit way2,
                                     output logic [31:0] tgt, output logic [1:0] st);
      logic [63:0] w;
      hit = 0; way2 = 0; tgt = '0; st = '0;
      for (int k = 0; k < 2; k++) begin
         w = (k == 0) ? m_set[pc[4:2]][127:64] : m_set[pc[4:2]][63:0];
         if (!hit && w[63] && (w[62:36] == pc[31:5])) begin
            hit  = 1;
            way2 = (k == 1);
            tgt  = w[35:4];
            st   = w[3:2];
         end
      end
   endfunction

   task automatic check_outputs();
      bit hit, way2, pv;
      logic [31:0] tgt;
      logic [1:0]  st;
      m_predict(bus.read_pc, hit, way2, tgt, st);
      pv = bus.read_en && !m_busy && hit;
      check("predict_valid",  128'(bus.predict_valid),  128'(pv));
      check("predict_taken",  128'(bus.predict_taken),  128'(pv && st[1]));
      check("predict_target", 128'(bus.predict_target), 128'(pv ? tgt : 32'h0));
      check("update_set",     bus.update_set,           m_set[bus.update_pc[4:2]]);
      check("lru_out",        128'(bus.lru_out),        128'(m_lru));
      check("update_tag",     128'(bus.update_tag),     128'(bus.update_pc[31:5]));
      check("update_index",   128'(bus.update_index),   128'(bus.update_pc[4:2]));
      check("flush_busy",     128'(bus.flush_busy),     128'(m_busy));
   endtask

   // Clock-edge effect of the current inputs on the model; EX commit is applied
   // after the IF touch so it overrides the touch on a shared index.
   task automatic model_edge();
      bit hit, way2, pv;
      logic [31:0] tgt;
      logic [1:0]  st;
      int ri, ui;
      m_predict(bus.read_pc, hit, way2, tgt, st);
      pv = bus.read_en && !m_busy && hit;
      ri = int'(bus.read_pc[4:2]);
      ui = int'(bus.update_pc[4:2]);
      if (m_busy) begin
         m_set[m_pos][127] = 1'b0;
         m_set[m_pos][63]  = 1'b0;
         m_lru[m_pos]      = 1'b0;
         if (bus.flush) m_pos = 0;
         else if (m_pos == 7) begin m_busy = 0; m_pos = 0; end
         else m_pos++;
      end else begin
         if (pv) m_lru[ri] = way2;
         if (bus.update_en) begin
            m_set[ui] = bus.write_set;
            m_lru[ui] = bus.next_lru_write;
         end
         if (bus.flush) begin m_busy = 1; m_pos = 0; end
      end
   endtask

   // Called between edges; returns 1 time unit after the next rising edge.
   task automatic step();
      #2;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      bus.read_en        = 1'b0;
      bus.read_pc        = '0;
      bus.update_en      = 1'b0;
      bus.update_pc      = '0;
      bus.write_set      = '0;
      bus.next_lru_write = 1'b0;
      bus.flush          = 1'b0;
   endtask

   function automatic logic [63:0] mk_way(input bit v, input logic [26:0] tag,
                                          input logic [31:0] tgt, input logic [1:0] st);
      return {v, tag, tgt, st, 2'b00};
   endfunction

   task automatic directed_commit();
      idle_inputs();
      bus.update_pc      = 32'h0000_0104;
      bus.write_set      = {mk_way(1, 27'd8, 32'h0000_0200, 2'b11), 64'h0};
      bus.next_lru_write = 1'b0;
      bus.update_en      = 1'b1;
      step();
      idle_inputs();
      bus.read_en = 1'b1;
      bus.read_pc = 32'h0000_0104;
      #1;
      check("dir_hit",    128'(bus.predict_valid),  128'(1'b1));
      check("dir_taken",  128'(bus.predict_taken),  128'(1'b1));
      check("dir_target", 128'(bus.predict_target), 128'(32'h0000_0200));
      check("dir_lru1",   128'(bus.lru_out[1]),     128'(1'b0));
      step();
   endtask

   int unsigned busy_cnt;
   bit          b;

   initial begin
      n_vec = 0;
      n_bad = 0;
      idle_inputs();
      m_reset();
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check("rst_pv",  128'(bus.predict_valid), 128'(1'b0));
      check("rst_lru", 128'(bus.lru_out),       128'(8'h00));
      check("rst_busy",128'(bus.flush_busy),    128'(1'b0));
      for (int i = 0; i < 8; i++) begin
         bus.update_pc = {27'd0, 3'(i), 2'b00};
         #1;
         check("rst_set", bus.update_set, 128'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      directed_commit();

      // LRU touch: entry in way2 of index 1, then an EX commit on the same index wins.
      idle_inputs();
      bus.update_pc = 32'h0000_0104;
      bus.write_set = {64'h0, mk_way(1, 27'd8, 32'h0000_0300, 2'b01)};
      bus.update_en = 1'b1;
      step();
      idle_inputs();
      bus.read_en = 1'b1;
      bus.read_pc = 32'h0000_0104;
      step();
      check("touch_way2", 128'(bus.lru_out[1]), 128'(1'b1));
      bus.update_en      = 1'b1;
      bus.update_pc      = 32'h0000_0104;
      bus.write_set      = {64'h0, mk_way(1, 27'd8, 32'h0000_0300, 2'b01)};
      bus.next_lru_write = 1'b0;
      step();
      check("ex_wins", 128'(bus.lru_out[1]), 128'(1'b0));

      // Fill every set, then sweep.
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         bus.update_en      = 1'b1;
         bus.update_pc      = {27'd8, 3'(i), 2'b00};
         bus.write_set      = {mk_way(1, 27'd8, 32'($urandom), 2'b10),
                               mk_way(1, 27'd9, 32'($urandom), 2'b01)};
         bus.next_lru_write = 1'b1;
         step();
      end
      idle_inputs();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         b = bus.flush_busy;
         if (b) busy_cnt++;
         bus.read_en   = 1'b1;
         bus.read_pc   = {27'd8, 3'd2, 2'b00};
         bus.update_en = b;
         bus.update_pc = {27'd8, 3'd5, 2'b00};
         bus.write_set = {mk_way(1, 27'd8, 32'h1234_5678, 2'b11), 64'h0};
         #1;
         if (b) check("sweep_pv", 128'(bus.predict_valid), 128'(1'b0));
         step();
      end
      check("flush_len", 128'(busy_cnt), 128'(8));
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         bus.update_pc = {27'd8, 3'(i), 2'b00};
         #1;
         check("swept_valid", 128'({bus.update_set[127], bus.update_set[63]}), 128'(2'b00));
         step();
      end
      check("swept_lru", 128'(bus.lru_out), 128'(8'h00));

      // Restart during the fifth busy cycle.
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.flush_busy) busy_cnt++;
         bus.flush = (c == 4);
         step();
      end
      bus.flush = 1'b0;
      check("restart_len", 128'(busy_cnt), 128'(13));

      // Reset in the third sweep cycle.
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      step();
      step();
      check("pre_rst_busy", 128'(bus.flush_busy), 128'(1'b1));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 128'(bus.flush_busy), 128'(1'b0));
      check("mid_rst_lru",  128'(bus.lru_out),    128'(8'h00));
      m_reset();
      #2 rst_n = 1'b1;
      directed_commit();

      // Random traffic over a small tag pool so hits and conflicts are frequent.
      for (int n = 0; n < 500; n++) begin
         bus.read_en        = ($urandom_range(9) < 8);
         bus.read_pc        = {25'd0, 2'($urandom), 3'($urandom), 2'($urandom)};
         bus.update_en      = ($urandom_range(1) == 1);
         bus.update_pc      = {25'd0, 2'($urandom), 3'($urandom), 2'($urandom)};
         bus.write_set      = {mk_way($urandom_range(3) != 0, {25'd0, 2'($urandom)},
                                      32'($urandom), 2'($urandom)),
                               mk_way($urandom_range(3) != 0, {25'd0, 2'($urandom)},
                                      32'($urandom), 2'($urandom))};
         bus.next_lru_write = 1'($urandom);
         bus.flush          = ($urandom_range(49) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
